// File: rtl/alu_mc.sv
// Multi-cycle ALU: 8 ops, iterative SLL and shift-add MUL, valid/ready in and out.
// Define ALU_MUL_EN to build the iterative multiplier for op 7.
module alu_mc #(
    parameter int WIDTH      = 64,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             eq,
    output logic             zero,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    shamt;
    logic [CW-1:0]    step_amt;
    logic [WIDTH-1:0] quick;
    logic [WIDTH-1:0] sll_next;
    logic             long_sll;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mul_next;
    logic             is_mul;
`endif

    assign shamt    = CW'(b[SHW-1:0]);
    assign long_sll = (op == 3'd6) && (shamt > STEP);
    assign step_amt = (cnt < STEP) ? cnt : STEP;
    assign sll_next = acc << step_amt;
`ifdef ALU_MUL_EN
    assign mul_next = acc + (mplier[0] ? mcand : '0);
`endif

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    // Single-edge results; op 7 stays zero when the multiplier is not built
    always_comb begin
        quick = '0;
        case (op)
            3'd0: quick = a + b;
            3'd1: quick = a - b;
            3'd2: quick = a & b;
            3'd3: quick = a | b;
            3'd4: quick = a ^ b;
            3'd5: quick = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            3'd6: quick = a << shamt;
            3'd7: quick = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            result    <= '0;
            eq        <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
`ifdef ALU_MUL_EN
            mcand     <= '0;
            mplier    <= '0;
            is_mul    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        eq <= (a == b);
                        if (long_sll) begin
                            // The accept edge already performs the first step
                            acc   <= a << STEP;
                            cnt   <= shamt - STEP;
                            state <= EXEC;
`ifdef ALU_MUL_EN
                            is_mul <= 1'b0;
                        end else if (op == 3'd7) begin
                            acc    <= b[0] ? a : '0;
                            mcand  <= a << 1;
                            mplier <= b >> 1;
                            cnt    <= CW'(WIDTH - 1);
                            is_mul <= 1'b1;
                            state  <= EXEC;
`endif
                        end else begin
                            result    <= quick;
                            zero      <= (quick == '0);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                EXEC: begin
`ifdef ALU_MUL_EN
                    if (is_mul) begin
                        acc    <= mul_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            result    <= mul_next;
                            zero      <= (mul_next == '0);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end else
`endif
                    begin
                        acc <= sll_next;
                        cnt <= cnt - step_amt;
                        if (cnt <= STEP) begin
                            result    <= sll_next;
                            zero      <= (sll_next == '0);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc against an arithmetic reference model.
// Follows ALU_MUL_EN the same way the design does.
module tb_alu_mc;
    localparam int WIDTH = 64;
    localparam int STEP  = 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             eq;
    logic             zero;
    logic             busy;

    int n_tests;
    int n_fail;

    alu_mc #(
        .WIDTH      (WIDTH),
        .SHIFT_STEP (STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .eq        (eq),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_res(input logic [2:0] o,
                                              input logic [63:0] x,
                                              input logic [63:0] y);
        logic [63:0] r;
        int sh;
        sh = int'(y[5:0]);
        case (o)
            3'd0: r = x + y;
            3'd1: r = x - y;
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
            3'd6: r = x << sh;
`ifdef ALU_MUL_EN
            default: r = x * y;
`else
            default: r = 64'd0;
`endif
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [63:0] y);
        int sh;
        sh = int'(y[5:0]);
        if (o == 3'd6) return (sh <= STEP) ? 1 : (sh + STEP - 1) / STEP;
`ifdef ALU_MUL_EN
        if (o == 3'd7) return WIDTH;
`endif
        return 1;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [63:0] x,
                          input logic [63:0] y, input int hold);
        logic [63:0] er;
        int lat;
        logic rdy_low;
        er = model_res(o, x, y);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        lat     = 1;
        rdy_low = 1'b1;
        // Garbage on the inputs while busy must be ignored
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        op = 3'($urandom_range(0, 7));
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_low = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, model_lat(o, y));
        check("result", result, er);
        check("eq", eq, x == y);
        check("zero", zero, er == 64'd0);
        check("in_ready_busy", rdy_low && !in_ready, 1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_result", result, er);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
        check("result_kept", result, er);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_eq", eq, 0);
        check("rst_zero", zero, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        run_op(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
        check("add_wrap_zero", zero, 1);
        run_op(3'd1, 64'h0000111100002222, 64'h0000111100002222, 0);
        check("sub_eq", eq, 1);
        run_op(3'd2, 64'h0000111100002222, 64'h0000111100002222, 0);
        check("and_res", result, 64'h0000111100002222);
        run_op(3'd6, 64'd1, 64'd63, 0);
        check("sll_63", result, 64'h8000_0000_0000_0000);
        run_op(3'd6, 64'h1234, 64'd0, 0);
        run_op(3'd6, 64'h1234, 64'd1, 1);
        run_op(3'd7, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0003, 0);
        run_op(3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5);
        check("slt_one", result, 64'd1);

        // Reset pulse in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1;
        op       = 3'd7;
        a        = 64'h0000_0001_0000_0000;
        b        = 64'h0000_0001_0000_0003;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd4, 64'hF0F0_0000_1111_2222, 64'h0F0F_0000_1111_0000, 0);

        for (int k = 0; k < 150; k++) begin
            logic [2:0]  ro;
            logic [63:0] ra;
            logic [63:0] rb;
            ro = 3'($urandom_range(0, 7));
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
            run_op(ro, ra, rb, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
